// File: rtl/bram_bank_scheduler_if.sv
// rtl/bram_bank_scheduler_if.sv - producer/backend handshake bundle for the BRAM bank scheduler
interface bram_bank_scheduler_if #(
    parameter int BANK_W = 1,
    parameter int LEN_W  = 16
);
    logic              prod_req;
    logic              prod_grant;
    logic [BANK_W-1:0] prod_bank;
    logic              prod_done;
    logic [LEN_W-1:0]  prod_length;
    logic              prod_abort;
    logic              be_start;
    logic [BANK_W-1:0] be_bank;
    logic [LEN_W-1:0]  be_length;
    logic              be_finish;
    logic [BANK_W-1:0] wr_bank_sel;
    logic [BANK_W-1:0] rd_bank_sel;
    logic [BANK_W:0]   free_cnt;
    logic [31:0]       pkt_cnt;
    logic              err;

    modport master (
        output prod_req, prod_done, prod_length, prod_abort, be_finish,
        input  prod_grant, prod_bank, be_start, be_bank, be_length,
               wr_bank_sel, rd_bank_sel, free_cnt, pkt_cnt, err
    );

    modport slave (
        input  prod_req, prod_done, prod_length, prod_abort, be_finish,
        output prod_grant, prod_bank, be_start, be_bank, be_length,
               wr_bank_sel, rd_bank_sel, free_cnt, pkt_cnt, err
    );
endinterface

// File: rtl/bram_bank_scheduler.sv
// rtl/bram_bank_scheduler.sv - round-robin ownership of packet BRAM banks between ingest and backend
module bram_bank_scheduler #(
    parameter int NUM_BANKS = 2,
    parameter int BANK_W    = 1,
    parameter int LEN_W     = 16
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    bram_bank_scheduler_if.slave bus
);
    localparam int CW = BANK_W + 1;

    typedef enum logic [1:0] {FREE, FILLING, READY, BUSY} bank_state_e;

    bank_state_e       state   [NUM_BANKS];
    logic [LEN_W-1:0]  len_mem [NUM_BANKS];
    logic [BANK_W-1:0] alloc_ptr;
    logic [BANK_W-1:0] disp_ptr;
    logic              filling;
    logic              busy;

    logic grant_go, done_go, abort_go, finish_go, disp_go, proto_err;

    // prod_bank / be_bank always name the FILLING / BUSY bank while the flags are set
    always_comb begin
        grant_go  = bus.prod_req && !filling && (state[alloc_ptr] == FREE);
        done_go   = bus.prod_done && filling;
        abort_go  = bus.prod_abort && !bus.prod_done && filling;
        finish_go = bus.be_finish && busy;
        disp_go   = !busy && (state[disp_ptr] == READY);
        proto_err = (bus.prod_done && !filling) || (bus.be_finish && !busy);
    end

    assign bus.wr_bank_sel = bus.prod_bank;
    assign bus.rd_bank_sel = bus.be_bank;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < NUM_BANKS; i++) begin
                state[i]   <= FREE;
                len_mem[i] <= '0;
            end
            alloc_ptr      <= '0;
            disp_ptr       <= '0;
            filling        <= 1'b0;
            busy           <= 1'b0;
            bus.prod_grant <= 1'b0;
            bus.prod_bank  <= '0;
            bus.be_start   <= 1'b0;
            bus.be_bank    <= '0;
            bus.be_length  <= '0;
            bus.free_cnt   <= CW'(NUM_BANKS);
            bus.pkt_cnt    <= '0;
            bus.err        <= 1'b0;
        end else begin
            bus.prod_grant <= grant_go;
            bus.be_start   <= disp_go;
            if (proto_err) begin
                bus.err <= 1'b1;
            end
            if (done_go) begin
                state[bus.prod_bank]   <= READY;
                len_mem[bus.prod_bank] <= bus.prod_length;
                filling                <= 1'b0;
            end
            // stepping the pointer back makes the aborted bank the next one allocated
            if (abort_go) begin
                state[bus.prod_bank] <= FREE;
                alloc_ptr            <= alloc_ptr - 1'b1;
                filling              <= 1'b0;
            end
            if (finish_go) begin
                state[bus.be_bank] <= FREE;
                busy               <= 1'b0;
            end
            if (disp_go) begin
                state[disp_ptr] <= BUSY;
                bus.be_bank     <= disp_ptr;
                bus.be_length   <= len_mem[disp_ptr];
                disp_ptr        <= disp_ptr + 1'b1;
                busy            <= 1'b1;
                bus.pkt_cnt     <= bus.pkt_cnt + 32'd1;
            end
            if (grant_go) begin
                state[alloc_ptr] <= FILLING;
                bus.prod_bank    <= alloc_ptr;
                alloc_ptr        <= alloc_ptr + 1'b1;
                filling          <= 1'b1;
            end
            bus.free_cnt <= bus.free_cnt + CW'(finish_go) + CW'(abort_go) - CW'(grant_go);
        end
    end
endmodule
